sram_port_arbiter: RTL and testbench

- Shares one read/write port of the dual-ported SRAM among NUM_REQ requesters using round-robin priority.
- Typical clients are the CPU data side, a DMA engine and a display fetch unit.
- Requesters can lock the port for atomic multi-cycle sequences, such as read-modify-write or short bursts.
- Read data is returned one cycle after the grant, tagged with the requester index.

---
 rtl/sram_arb_pkg.sv | 33 +++
 rtl/rr_picker.sv | 43 ++++
 rtl/sram_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
// Shared definitions for the SRAM port arbiters.
//   MAX_REQ     : largest supported requester count
//   MAX_LANE_W  : widest lane (address or data) that lane_slice can extract
//   arb_state_e : lock state of an arbiter (UNLOCKED / LOCKED)
//   lane_slice  : extracts one lane from a flattened per-requester bus
// -----------------------------------------------------------------------------
package sram_arb_pkg;

   localparam int MAX_REQ    = 8;
   localparam int MAX_LANE_W = 32;
   localparam int MAX_FLAT_W = MAX_REQ * MAX_LANE_W;

   typedef enum logic {
      ARB_UNLOCKED = 1'b0,
      ARB_LOCKED   = 1'b1
   } arb_state_e;

   // Returns lane 'idx' of a bus packed as lanes of 'lane_w' bits, lane 0 in
   // the LSBs. The caller zero-extends its bus to MAX_FLAT_W and truncates the
   // result back to lane_w; bits above lane_w belong to the next lane.
   function automatic logic [MAX_LANE_W-1:0] lane_slice(
      input logic [MAX_FLAT_W-1:0] flat,
      input int                    idx,
      input int                    lane_w
   );
      logic [MAX_FLAT_W-1:0] shifted;
      shifted = flat >> (idx * lane_w);
      return shifted[MAX_LANE_W-1:0];
   endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin pick: grants the first asserted request found by
// scanning upward from i_start, wrapping modulo N (not modulo 2^IDW).
// Ports:
//   i_req          [N]   request vector
//   i_start        [IDW] index with highest priority
//   o_grant_onehot [N]   one-hot grant (zero when nothing requested)
//   o_grant_idx    [IDW] index of the grant (zero when nothing requested)
//   o_any_grant          a grant was made
// -----------------------------------------------------------------------------
module rr_picker #(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   i_req,
   input  logic [IDW-1:0] i_start,
   output logic [N-1:0]   o_grant_onehot,
   output logic [IDW-1:0] o_grant_idx,
   output logic           o_any_grant
);

   function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
      return IDW'((int'(base) + off) % N);
   endfunction

   always_comb begin
      logic [IDW-1:0] w_cand;
      w_cand         = '0;
      o_grant_onehot = '0;
      o_grant_idx    = '0;
      o_any_grant    = 1'b0;
      for (int off = 0; off < N; off++) begin
         w_cand = wrap_add(i_start, off);
         if (!o_any_grant && i_req[w_cand]) begin
            o_any_grant            = 1'b1;
            o_grant_idx            = w_cand;
            o_grant_onehot[w_cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
// Shares one SRAM read/write port among NUM_REQ requesters with round-robin
// priority and an optional lock for atomic multi-cycle sequences. Read data
// returns one cycle after the grant, tagged with the requester index.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req/req_we/req_lock   per-requester request, write enable, hold lock
//   req_addr/req_wdata    flattened per-requester address / write data
//   ack                   one-hot, combinational acceptance
//   rvalid/rid/rdata      registered completion, requester tag, SRAM q
//   sram_addr/we/data     SRAM port drive
//   sram_q                SRAM read data (write-through on writes)
// -----------------------------------------------------------------------------
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 16,
   parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ-1:0]             req_we,
   input  logic [NUM_REQ-1:0]             req_lock,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]             ack,
   output logic                           rvalid,
   output logic [ID_WIDTH-1:0]            rid,
   output logic [DATA_WIDTH-1:0]          rdata,
   output logic [ADDR_WIDTH-1:0]          sram_addr,
   output logic                           sram_we,
   output logic [DATA_WIDTH-1:0]          sram_data,
   input  logic [DATA_WIDTH-1:0]          sram_q
);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   arb_state_e             r_state_reg;
   arb_state_e             w_state_next;
   logic [ID_WIDTH-1:0]    r_rr_ptr_reg;
   logic [ID_WIDTH-1:0]    w_rr_ptr_next;
   logic [ID_WIDTH-1:0]    r_owner_id_reg;
   logic [ID_WIDTH-1:0]    w_owner_id_next;
   logic                   r_rvalid_reg;
   logic [ID_WIDTH-1:0]    r_rid_reg;

   // ---------------------------------------------------------------------
   // Lane unpacking
   // ---------------------------------------------------------------------
   logic [MAX_FLAT_W-1:0]  w_addr_flat_ext;
   logic [MAX_FLAT_W-1:0]  w_wdata_flat_ext;
   logic [ADDR_WIDTH-1:0]  w_lane_addr  [NUM_REQ];
   logic [DATA_WIDTH-1:0]  w_lane_wdata [NUM_REQ];

   assign w_addr_flat_ext  = MAX_FLAT_W'(req_addr);
   assign w_wdata_flat_ext = MAX_FLAT_W'(req_wdata);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
         assign w_lane_addr[gi]  = ADDR_WIDTH'(lane_slice(w_addr_flat_ext, gi, ADDR_WIDTH));
         assign w_lane_wdata[gi] = DATA_WIDTH'(lane_slice(w_wdata_flat_ext, gi, DATA_WIDTH));
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Arbitration
   // While locked, the request vector is masked down to the owner's bit so
   // the same picker yields either the owner or nothing.
   // ---------------------------------------------------------------------
   logic [NUM_REQ-1:0]     w_owner_mask;
   logic [NUM_REQ-1:0]     w_pick_req;
   logic [ID_WIDTH-1:0]    w_pick_start;
   logic [NUM_REQ-1:0]     w_grant_onehot;
   logic [ID_WIDTH-1:0]    w_grant_idx;
   logic                   w_any_grant;
   logic                   w_locked;

   assign w_locked     = (r_state_reg == ARB_LOCKED);
   assign w_owner_mask = NUM_REQ'(1) << r_owner_id_reg;
   assign w_pick_req   = w_locked ? (req & w_owner_mask) : req;
   assign w_pick_start = w_locked ? r_owner_id_reg : r_rr_ptr_reg;

   rr_picker #(
      .N   (NUM_REQ),
      .IDW (ID_WIDTH)
   ) u_picker (
      .i_req          (w_pick_req),
      .i_start        (w_pick_start),
      .o_grant_onehot (w_grant_onehot),
      .o_grant_idx    (w_grant_idx),
      .o_any_grant    (w_any_grant)
   );

   // Pointer step wraps at NUM_REQ so non-power-of-two counts never reach an
   // unused index.
   logic [ID_WIDTH-1:0]    w_rr_after_grant;
   assign w_rr_after_grant = (w_grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                                     : w_grant_idx + ID_WIDTH'(1);

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state_reg    <= ARB_UNLOCKED;
         r_rr_ptr_reg   <= '0;
         r_owner_id_reg <= '0;
         r_rvalid_reg   <= 1'b0;
         r_rid_reg      <= '0;
      end else begin
         r_state_reg    <= w_state_next;
         r_rr_ptr_reg   <= w_rr_ptr_next;
         r_owner_id_reg <= w_owner_id_next;
         r_rvalid_reg   <= w_any_grant;
         if (w_any_grant) begin
            r_rid_reg <= w_grant_idx;
         end
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_next    = r_state_reg;
      w_rr_ptr_next   = r_rr_ptr_reg;
      w_owner_id_next = r_owner_id_reg;
      if (w_any_grant) begin
         case (r_state_reg)
            ARB_UNLOCKED: begin
               w_rr_ptr_next = w_rr_after_grant;
               if (req_lock[w_grant_idx]) begin
                  w_state_next    = ARB_LOCKED;
                  w_owner_id_next = w_grant_idx;
               end
            end
            ARB_LOCKED: begin
               // Priority pointer is frozen during a locked sequence; an owner
               // access without lock ends it.
               if (!req_lock[w_grant_idx]) begin
                  w_state_next = ARB_UNLOCKED;
               end
            end
            default: begin
               w_state_next = ARB_UNLOCKED;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------
   always_comb begin
      ack       = w_grant_onehot;
      sram_addr = w_lane_addr[w_grant_idx];
      sram_data = w_lane_wdata[w_grant_idx];
      sram_we   = w_any_grant & req_we[w_grant_idx];
   end

   assign rvalid = r_rvalid_reg;
   assign rid    = r_rid_reg;
   assign rdata  = sram_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_port_arbiter
// Table-driven directed vectors, a NUM_REQ=3 wrap sequence, and randomized
// traffic checked against a behavioural arbitration/memory model.
// -----------------------------------------------------------------------------
module tb_sram_port_arbiter;

   localparam int NR = 4;
   localparam int AW = 12;
   localparam int DW = 16;
   localparam int IW = 2;
   localparam int N_RAND = 500;

   logic              clk = 1'b0;
   logic              reset;
   logic [NR-1:0]     req, req_we, req_lock, ack;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*DW-1:0]  req_wdata;
   logic              rvalid;
   logic [IW-1:0]     rid;
   logic [DW-1:0]     rdata, sram_data, sram_q;
   logic [AW-1:0]     sram_addr;
   logic              sram_we;

   // three-requester instance
   logic [2:0]        req3, we3, lock3, ack3;
   logic [3*AW-1:0]   addr3;
   logic [3*DW-1:0]   wdata3;
   logic              rvalid3;
   logic [1:0]        rid3;
   logic [DW-1:0]     rdata3, sram_data3, sram_q3;
   logic [AW-1:0]     sram_addr3;
   logic              sram_we3;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sram_port_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_lock(req_lock),
      .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .rvalid(rvalid),
      .rid(rid), .rdata(rdata), .sram_addr(sram_addr), .sram_we(sram_we),
      .sram_data(sram_data), .sram_q(sram_q)
   );

   sram_port_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut3 (
      .clk(clk), .reset(reset), .req(req3), .req_we(we3), .req_lock(lock3),
      .req_addr(addr3), .req_wdata(wdata3), .ack(ack3), .rvalid(rvalid3),
      .rid(rid3), .rdata(rdata3), .sram_addr(sram_addr3), .sram_we(sram_we3),
      .sram_data(sram_data3), .sram_q(sram_q3)
   );
   assign sram_q3 = '0;

   // ---------------- SRAM model (write-through q) ----------------
   logic [DW-1:0] mem [0:4095];
   logic          mem_load;

   function automatic logic [DW-1:0] init_val(input int a);
      return (a == 16) ? 16'h1234 : DW'(a * 37 + 5);
   endfunction

   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
      end else if (sram_we) begin
         mem[sram_addr] <= sram_data;
         sram_q         <= sram_data;
      end else begin
         sram_q <= mem[sram_addr];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic          rst;
      logic [NR-1:0] rq, we, lk;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [NR-1:0] ack;
      logic          chk_rv;
      logic          rv;
      logic [IW-1:0] rid;
      logic [DW-1:0] rdata;
   } vec_t;

   function automatic vec_t mk(input logic rst, input logic [NR-1:0] rq, input logic [NR-1:0] we,
                               input logic [NR-1:0] lk, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [NR-1:0] ak,
                               input logic crv, input logic rv, input logic [IW-1:0] id,
                               input logic [DW-1:0] rd);
      vec_t v;
      v.rst = rst; v.rq = rq; v.we = we; v.lk = lk; v.addr = addr; v.wdata = wdata;
      v.ack = ak; v.chk_rv = crv; v.rv = rv; v.rid = id; v.rdata = rd;
      return v;
   endfunction

   vec_t tbl [24];

   // ---------------- behavioural reference model ----------------
   logic [DW-1:0] ref_mem [0:4095];
   int            m_rr, m_owner, m_rid;
   bit            m_locked, m_rv;
   logic [DW-1:0] m_rdata;

   // Round-robin rule: owner only while locked, else first requester at or
   // after the priority pointer, wrapping around the NR requesters.
   function automatic int model_pick(input logic [NR-1:0] r);
      if (m_locked) return r[m_owner] ? m_owner : -1;
      for (int k = 0; k < NR; k++) begin
         if (r[(m_rr + k) % NR]) return (m_rr + k) % NR;
      end
      return -1;
   endfunction

   logic [NR-1:0] pend, lwe, llock;
   logic [AW-1:0] laddr [NR];
   logic [DW-1:0] lwdata [NR];

   initial begin
      int g;
      logic [NR-1:0] exp_ack;
      reset = 1'b1; mem_load = 1'b1;
      req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
      req3 = '0; we3 = '0; lock3 = '0; addr3 = '0; wdata3 = '0;
      @(posedge clk); #1;
      mem_load = 1'b0;

      //            rst rq     we     lk     addr    wdata    ack   crv rv rid rdata
      tbl[0]  = mk(1, 4'h0, 4'h0, 4'h0, 12'h010, 16'h0,   4'h0, 0, 0, 0, 16'h0);
      tbl[1]  = mk(1, 4'h0, 4'h0, 4'h0, 12'h010, 16'h0,   4'h0, 1, 0, 0, 16'h0);
      tbl[2]  = mk(0, 4'h0, 4'h0, 4'h0, 12'h010, 16'h0,   4'h0, 1, 0, 0, 16'h0);
      tbl[3]  = mk(0, 4'hF, 4'h0, 4'h0, 12'h010, 16'h0,   4'h1, 1, 0, 0, 16'h0);
      tbl[4]  = mk(0, 4'hF, 4'h0, 4'h0, 12'h010, 16'h0,   4'h2, 1, 1, 0, 16'h1234);
      tbl[5]  = mk(0, 4'hF, 4'h0, 4'h0, 12'h010, 16'h0,   4'h4, 1, 1, 1, 16'h1234);
      tbl[6]  = mk(0, 4'hF, 4'h0, 4'h0, 12'h010, 16'h0,   4'h8, 1, 1, 2, 16'h1234);
      tbl[7]  = mk(0, 4'hF, 4'h0, 4'h0, 12'h010, 16'h0,   4'h1, 1, 1, 3, 16'h1234);
      tbl[8]  = mk(0, 4'hF, 4'h0, 4'h0, 12'h010, 16'h0,   4'h2, 1, 1, 0, 16'h1234);
      tbl[9]  = mk(0, 4'hF, 4'h0, 4'h0, 12'h010, 16'h0,   4'h4, 1, 1, 1, 16'h1234);
      tbl[10] = mk(0, 4'hF, 4'h0, 4'h0, 12'h010, 16'h0,   4'h8, 1, 1, 2, 16'h1234);
      tbl[11] = mk(0, 4'h1, 4'h0, 4'h0, 12'h010, 16'h0,   4'h1, 1, 1, 3, 16'h1234);
      tbl[12] = mk(0, 4'h4, 4'h4, 4'h0, 12'h055, 16'hBEEF, 4'h4, 1, 1, 0, 16'h1234);
      tbl[13] = mk(0, 4'h2, 4'h0, 4'h0, 12'h055, 16'h0,   4'h2, 1, 1, 2, 16'hBEEF);
      tbl[14] = mk(0, 4'h0, 4'h0, 4'h0, 12'h055, 16'h0,   4'h0, 1, 1, 1, 16'hBEEF);
      tbl[15] = mk(0, 4'h2, 4'h0, 4'h2, 12'h010, 16'h0,   4'h2, 1, 0, 0, 16'h0);
      tbl[16] = mk(0, 4'hF, 4'h0, 4'h2, 12'h010, 16'h0,   4'h2, 1, 1, 1, 16'h1234);
      tbl[17] = mk(0, 4'hD, 4'h0, 4'h2, 12'h010, 16'h0,   4'h0, 1, 1, 1, 16'h1234);
      tbl[18] = mk(0, 4'hF, 4'h0, 4'h2, 12'h010, 16'h0,   4'h2, 1, 0, 0, 16'h0);
      tbl[19] = mk(0, 4'hF, 4'h0, 4'h0, 12'h010, 16'h0,   4'h2, 1, 1, 1, 16'h1234);
      tbl[20] = mk(0, 4'hF, 4'h0, 4'h0, 12'h010, 16'h0,   4'h4, 1, 1, 1, 16'h1234);
      tbl[21] = mk(1, 4'h8, 4'h0, 4'h8, 12'h010, 16'h0,   4'h8, 1, 1, 2, 16'h1234);
      tbl[22] = mk(0, 4'hF, 4'h0, 4'h0, 12'h010, 16'h0,   4'h1, 1, 0, 0, 16'h0);
      tbl[23] = mk(0, 4'h0, 4'h0, 4'h0, 12'h010, 16'h0,   4'h0, 1, 1, 0, 16'h1234);

      for (int v = 0; v < 24; v++) begin
         reset     = tbl[v].rst;
         req       = tbl[v].rq;
         req_we    = tbl[v].we;
         req_lock  = tbl[v].lk;
         req_addr  = {NR{tbl[v].addr}};
         req_wdata = {NR{tbl[v].wdata}};
         @(negedge clk);
         $display("vec %0d: rst=%b req=%b ack=%b rvalid=%b rid=%0d rdata=%h",
                  v, reset, req, ack, rvalid, rid, rdata);
         check($sformatf("vec%0d_ack", v), 32'(ack), 32'(tbl[v].ack));
         if (tbl[v].chk_rv) begin
            check($sformatf("vec%0d_rvalid", v), 32'(rvalid), 32'(tbl[v].rv));
            if (tbl[v].rv) begin
               check($sformatf("vec%0d_rid", v), 32'(rid), 32'(tbl[v].rid));
               check($sformatf("vec%0d_rdata", v), 32'(rdata), 32'(tbl[v].rdata));
            end else if (v < 3) begin
               check($sformatf("vec%0d_rid_reset", v), 32'(rid), 32'(tbl[v].rid));
            end
         end
         if (tbl[v].ack != '0) begin
            check($sformatf("vec%0d_sram_we", v), 32'(sram_we), 32'((tbl[v].we & tbl[v].ack) != '0));
            check($sformatf("vec%0d_sram_addr", v), 32'(sram_addr), 32'(tbl[v].addr));
            if (sram_we) check($sformatf("vec%0d_sram_data", v), 32'(sram_data), 32'(tbl[v].wdata));
         end else begin
            check($sformatf("vec%0d_sram_we_idle", v), 32'(sram_we), 32'(0));
         end
         @(posedge clk); #1;
      end
      reset = 1'b0; req = '0; req_lock = '0; req_we = '0;

      // ---------------- NUM_REQ=3 wrap sequence ----------------
      for (int k = 0; k < 6; k++) begin
         req3 = 3'b111;
         @(negedge clk);
         $display("n3 %0d: ack=%b rvalid=%b rid=%0d", k, ack3, rvalid3, rid3);
         check($sformatf("n3_ack%0d", k), 32'(ack3), 32'(1 << (k % 3)));
         if (k > 0) begin
            check($sformatf("n3_rvalid%0d", k), 32'(rvalid3), 32'(1));
            check($sformatf("n3_rid%0d", k), 32'(rid3), 32'((k - 1) % 3));
         end
         @(posedge clk); #1;
      end
      req3 = '0;

      // ---------------- randomized traffic vs model ----------------
      reset = 1'b1; mem_load = 1'b1; req = '0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
      m_rr = 0; m_owner = 0; m_locked = 0; m_rv = 0; m_rid = 0; m_rdata = '0;
      pend = '0; lwe = '0; llock = '0;
      for (int i = 0; i < NR; i++) begin laddr[i] = '0; lwdata[i] = '0; end
      @(posedge clk); #1;
      reset = 1'b0; mem_load = 1'b0;

      for (int c = 0; c < N_RAND; c++) begin
         for (int i = 0; i < NR; i++) begin
            if (!pend[i]) begin
               pend[i]   = ($urandom_range(0, 99) < 60);
               lwe[i]    = 1'($urandom_range(0, 1));
               llock[i]  = ($urandom_range(0, 99) < 30);
               laddr[i]  = AW'($urandom_range(0, 15));
               lwdata[i] = DW'($urandom);
            end
            req_addr[i*AW +: AW]  = laddr[i];
            req_wdata[i*DW +: DW] = lwdata[i];
         end
         req      = pend;
         req_we   = lwe;
         req_lock = llock;
         reset    = ($urandom_range(0, 99) == 0);
         @(negedge clk);
         g = model_pick(req);
         exp_ack = (g >= 0) ? NR'(1 << g) : '0;
         check("rnd_ack", 32'(ack), 32'(exp_ack));
         check("rnd_rvalid", 32'(rvalid), 32'(m_rv));
         if (m_rv) begin
            check("rnd_rid", 32'(rid), 32'(m_rid));
            check("rnd_rdata", 32'(rdata), 32'(m_rdata));
         end
         check("rnd_sram_we", 32'(sram_we), (g >= 0) ? 32'(lwe[g]) : 32'(0));
         if (g >= 0) begin
            check("rnd_sram_addr", 32'(sram_addr), 32'(laddr[g]));
            if (lwe[g]) check("rnd_sram_data", 32'(sram_data), 32'(lwdata[g]));
            $display("rnd %0d: rst=%b grant=%0d we=%b lock=%b addr=%h", c, reset, g, lwe[g], llock[g], laddr[g]);
            // memory effect happens even in a reset cycle (SRAM sees the write)
            if (lwe[g]) begin
               m_rdata = lwdata[g];
               ref_mem[laddr[g]] = lwdata[g];
            end else begin
               m_rdata = ref_mem[laddr[g]];
            end
            m_rv  = 1;
            m_rid = g;
            if (!m_locked) begin
               m_rr = (g + 1) % NR;
               if (llock[g]) begin m_locked = 1; m_owner = g; end
            end else if (!llock[g]) begin
               m_locked = 0;
            end
            pend[g] = 1'b0;
         end else begin
            $display("rnd %0d: rst=%b no grant", c, reset);
            m_rv = 0;
         end
         if (reset) begin
            m_rr = 0; m_locked = 0; m_rv = 0;
         end
         @(posedge clk); #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
